// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions for the SHA256d nonce scheduler.
// Contents:
//   SHA256_IV                   standard initial hash value (H0..H7)
//   PAD_WORD, LEN1/LEN2_WORD    padding and bit-length words for pass 1 (80 B) and pass 2 (32 B)
//   sched_state_e               scheduler FSM state encoding
//   bswap32, bswap256           byte-order reversal helpers
//   pass1_block, pass2_block    assemble the 16-word compression blocks
package sha256_pkg;

  localparam logic [255:0] SHA256_IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] PAD_WORD  = 32'h80000000;
  // 80-byte header = 640 bits; 32-byte digest = 256 bits
  localparam logic [31:0] LEN1_WORD = 32'h00000280;
  localparam logic [31:0] LEN2_WORD = 32'h00000100;

  typedef enum logic [2:0] {
    StIdle,
    StH1Issue,
    StH1Wait,
    StH2Issue,
    StH2Wait,
    StCheck
  } sched_state_e;

  function automatic logic [31:0] bswap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  function automatic logic [255:0] bswap256(input logic [255:0] x);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      r[8*i +: 8] = x[255-8*i -: 8];
    end
    return r;
  endfunction

  // Second 64-byte block of the header: words 16..18, the nonce in header byte order, padding.
  function automatic logic [511:0] pass1_block(input logic [95:0] tail, input logic [31:0] nonce);
    return {tail, bswap32(nonce), PAD_WORD, 320'h0, LEN1_WORD};
  endfunction

  // Single padded block holding the 32-byte pass-1 digest.
  function automatic logic [511:0] pass2_block(input logic [255:0] digest);
    return {digest, PAD_WORD, 192'h0, LEN2_WORD};
  endfunction

endpackage

// File: rtl/sha256d_nonce_sched_if.sv
// Link between the nonce scheduler and the single-pass SHA-256 compression core.
//   core_en        one-cycle compress strobe
//   core_midstate  chaining value fed to the core
//   core_block     16-word message block, word0 in [511:480]
//   core_hash      digest returned by the core
// master: scheduler side; slave: core wrapper side.
interface sha256d_nonce_sched_if;
  logic         core_en;
  logic [255:0] core_midstate;
  logic [511:0] core_block;
  logic [255:0] core_hash;

  modport master (
    output core_en,
    output core_midstate,
    output core_block,
    input  core_hash
  );

  modport slave (
    input  core_en,
    input  core_midstate,
    input  core_block,
    output core_hash
  );
endinterface

// File: rtl/sha256d_nonce_sched.sv
// Drives one external SHA-256 compression core through Bitcoin double-SHA256 over a nonce
// range and stops on the first digest that is <= the target, or when the range is exhausted.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset (deassertion synchronised here)
//   start, stop         begin search (idle only) / abort search; stop wins over start
//   cfg_midstate/tail   header midstate and words 16..18, latched at start
//   cfg_target          256-bit unsigned target, latched at start
//   nonce_start/end     inclusive nonce range, wraps through FFFFFFFF -> 0
//   busy, done          search active / one-cycle end-of-search pulse
//   found, found_nonce,
//   found_hash          result of the last search
//   hash_count          nonces checked since reset (only with SHA256D_HASH_COUNT_EN)
//   core                master side of the compression core link
// Optional feature macro: SHA256D_HASH_COUNT_EN.
module sha256d_nonce_sched
  import sha256_pkg::*;
#(
  parameter int unsigned CORE_LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         stop,
  input  logic [255:0] cfg_midstate,
  input  logic [95:0]  cfg_tail,
  input  logic [255:0] cfg_target,
  input  logic [31:0]  nonce_start,
  input  logic [31:0]  nonce_end,
  output logic         busy,
  output logic         done,
  output logic         found,
  output logic [31:0]  found_nonce,
  output logic [255:0] found_hash,
`ifdef SHA256D_HASH_COUNT_EN
  output logic [63:0]  hash_count,
`endif
  sha256d_nonce_sched_if.master core
);

  localparam int unsigned LatW = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;
  localparam logic [LatW-1:0] LatLast = LatW'(CORE_LAT - 1);

  // Reset asserts asynchronously, releases two clocks later
  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_int_n = rst_sync_q[1];

  sched_state_e    state_q, state_d;
  logic [LatW-1:0] lat_q, lat_d;
  logic [31:0]     nonce_q, nonce_d, nonce_end_q, nonce_end_d;
  logic [255:0]    mid_q, mid_d, target_q, target_d, hash2_q, hash2_d;
  logic [95:0]     tail_q, tail_d;
  logic            busy_q, busy_d, done_q, done_d, found_q, found_d, en_q, en_d;
  logic [31:0]     found_nonce_q, found_nonce_d;
  logic [255:0]    found_hash_q, found_hash_d, cmid_q, cmid_d;
  // Upper half of the pass-2 block is hash1, so the block register doubles as its store
  logic [511:0]    cblk_q, cblk_d;
  logic            lat_last, hit;

  assign lat_last = (lat_q == LatLast);
  assign hit      = (bswap256(hash2_q) <= target_q);

  always_comb begin
    state_d       = state_q;
    lat_d         = lat_q;
    nonce_d       = nonce_q;
    nonce_end_d   = nonce_end_q;
    mid_d         = mid_q;
    tail_d        = tail_q;
    target_d      = target_q;
    hash2_d       = hash2_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    found_d       = found_q;
    found_nonce_d = found_nonce_q;
    found_hash_d  = found_hash_q;
    en_d          = 1'b0;
    cmid_d        = cmid_q;
    cblk_d        = cblk_q;

    if (stop && (state_q != StIdle)) begin
      // Abort: drop any in-flight core result, no done pulse
      state_d = StIdle;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start && !stop) begin
            mid_d       = cfg_midstate;
            tail_d      = cfg_tail;
            target_d    = cfg_target;
            nonce_d     = nonce_start;
            nonce_end_d = nonce_end;
            found_d     = 1'b0;
            busy_d      = 1'b1;
            en_d        = 1'b1;
            cmid_d      = cfg_midstate;
            cblk_d      = pass1_block(cfg_tail, nonce_start);
            state_d     = StH1Issue;
          end
        end
        StH1Issue: begin
          lat_d   = '0;
          state_d = StH1Wait;
        end
        StH1Wait: begin
          if (lat_last) begin
            en_d    = 1'b1;
            cmid_d  = SHA256_IV;
            cblk_d  = pass2_block(core.core_hash);
            state_d = StH2Issue;
          end else begin
            lat_d = lat_q + 1'b1;
          end
        end
        StH2Issue: begin
          lat_d   = '0;
          state_d = StH2Wait;
        end
        StH2Wait: begin
          if (lat_last) begin
            hash2_d = core.core_hash;
            state_d = StCheck;
          end else begin
            lat_d = lat_q + 1'b1;
          end
        end
        StCheck: begin
          if (hit) begin
            found_d       = 1'b1;
            found_nonce_d = nonce_q;
            found_hash_d  = hash2_q;
            done_d        = 1'b1;
            busy_d        = 1'b0;
            state_d       = StIdle;
          end else if (nonce_q == nonce_end_q) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = StIdle;
          end else begin
            nonce_d = nonce_q + 32'd1;
            en_d    = 1'b1;
            cmid_d  = mid_q;
            cblk_d  = pass1_block(tail_q, nonce_q + 32'd1);
            state_d = StH1Issue;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q       <= StIdle;
      lat_q         <= '0;
      nonce_q       <= '0;
      nonce_end_q   <= '0;
      mid_q         <= '0;
      tail_q        <= '0;
      target_q      <= '0;
      hash2_q       <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      found_q       <= 1'b0;
      found_nonce_q <= '0;
      found_hash_q  <= '0;
      en_q          <= 1'b0;
      cmid_q        <= '0;
      cblk_q        <= '0;
    end else begin
      state_q       <= state_d;
      lat_q         <= lat_d;
      nonce_q       <= nonce_d;
      nonce_end_q   <= nonce_end_d;
      mid_q         <= mid_d;
      tail_q        <= tail_d;
      target_q      <= target_d;
      hash2_q       <= hash2_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      found_q       <= found_d;
      found_nonce_q <= found_nonce_d;
      found_hash_q  <= found_hash_d;
      en_q          <= en_d;
      cmid_q        <= cmid_d;
      cblk_q        <= cblk_d;
    end
  end

`ifdef SHA256D_HASH_COUNT_EN
  logic [63:0] cnt_q;

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n)                            cnt_q <= '0;
    else if (state_q == StCheck && ~&cnt_q)    cnt_q <= cnt_q + 64'd1;
  end
  assign hash_count = cnt_q;
`else
  // Hash counter not built
`endif

  assign busy               = busy_q;
  assign done               = done_q;
  assign found              = found_q;
  assign found_nonce        = found_nonce_q;
  assign found_hash         = found_hash_q;
  assign core.core_en       = en_q;
  assign core.core_midstate = cmid_q;
  assign core.core_block    = cblk_q;

endmodule

// File: tb/tb_sha256d_nonce_sched.sv
// Directed bench for sha256d_nonce_sched with a behavioural SHA-256 compression core
// (one-cycle latency) attached to the core link.
module tb_sha256d_nonce_sched;

  localparam logic [255:0] TB_IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic         clk = 1'b0;
  logic         rst_n, start, stop;
  logic [255:0] cfg_midstate, cfg_target;
  logic [95:0]  cfg_tail;
  logic [31:0]  nonce_start, nonce_end;
  logic         busy, done, found;
  logic [31:0]  found_nonce;
  logic [255:0] found_hash;
`ifdef SHA256D_HASH_COUNT_EN
  logic [63:0]  hash_count;
`endif

  int checks = 0;
  int errors = 0;

  sha256d_nonce_sched_if core_if ();

  sha256d_nonce_sched #(.CORE_LAT(1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .stop         (stop),
    .cfg_midstate (cfg_midstate),
    .cfg_tail     (cfg_tail),
    .cfg_target   (cfg_target),
    .nonce_start  (nonce_start),
    .nonce_end    (nonce_end),
    .busy         (busy),
    .done         (done),
    .found        (found),
    .found_nonce  (found_nonce),
    .found_hash   (found_hash),
`ifdef SHA256D_HASH_COUNT_EN
    .hash_count   (hash_count),
`endif
    .core         (core_if)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_compress(input logic [255:0] h, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, hh, t1, t2;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      w[i] = w[i-16] + (rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-7]
           + (rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10));
    end
    {a, b, c, d, e, f, g, hh} = h;
    for (int i = 0; i < 64; i++) begin
      t1 = hh + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {h[255:224] + a, h[223:192] + b, h[191:160] + c, h[159:128] + d,
            h[127:96] + e, h[95:64] + f, h[63:32] + g, h[31:0] + hh};
  endfunction

  function automatic logic [255:0] tb_bswap256(input logic [255:0] x);
    logic [255:0] r;
    for (int i = 0; i < 32; i++) r[8*i +: 8] = x[255-8*i -: 8];
    return r;
  endfunction

  function automatic logic [255:0] dsha(input logic [255:0] mid, input logic [95:0] tail,
                                        input logic [31:0] n);
    logic [255:0] h1;
    h1 = sha_compress(mid, {tail, n[7:0], n[15:8], n[23:16], n[31:24], 32'h80000000, 320'h0,
                            32'h00000280});
    return sha_compress(TB_IV, {h1, 32'h80000000, 192'h0, 32'h00000100});
  endfunction

  // Behavioural compression core, result valid the cycle after the strobe
  always @(posedge clk) begin
    if (core_if.core_en === 1'b1)
      core_if.core_hash <= sha_compress(core_if.core_midstate, core_if.core_block);
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Leaves the bench in cycle 1 after the start-accept edge
  task automatic start_run();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 1;
    while (done !== 1'b1 && cyc < 300) begin
      step(1);
      cyc++;
    end
  endtask

  logic [255:0] gen_mid;
  logic [95:0]  gen_tail;
  int           cyc;
  logic         seen_done, seen_en;

  initial begin
    gen_mid  = sha_compress(TB_IV, {32'h01000000, 256'h0,
                 224'h3ba3edfd7a7b12b27ac72c3e67768f617fc81bc3888a51323a9fb8aa});
    gen_tail = 96'h4b1e5e4a_29ab5f49_ffff001d;

    rst_n = 1'b0; start = 1'b0; stop = 1'b0;
    cfg_midstate = gen_mid; cfg_tail = gen_tail; cfg_target = '0;
    nonce_start = '0; nonce_end = '0;
    step(3);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_found", found, 0);
    chk("rst_core_en", core_if.core_en, 0);
    rst_n = 1'b1;
    step(3);

    // Genesis block: third nonce in range hits
    cfg_target  = {32'h00000000, 32'hffff0000, 192'h0};
    nonce_start = 32'h7c2bac1b;
    nonce_end   = 32'h7c2bac20;
    start_run();
    chk("gen_busy", busy, 1);
    chk("gen_core_en", core_if.core_en, 1);
    chk("gen_core_mid", core_if.core_midstate, gen_mid);
    wait_done(cyc);
    chk("gen_done_cycle", cyc, 16);
    chk("gen_found", found, 1);
    chk("gen_nonce", found_nonce, 32'h7c2bac1d);
    chk("gen_hash", tb_bswap256(found_hash),
        256'h000000000019d6689c085ae165831e934ff763ae46a2a6c172b3f1b60a8ce26f);
    chk("gen_busy_end", busy, 0);
    step(1);
    chk("gen_done_pulse", done, 0);
    chk("gen_found_held", found, 1);

    // Exhaustion: nothing can beat target 0
    cfg_target  = '0;
    nonce_start = 32'd5;
    nonce_end   = 32'd7;
    start_run();
    chk("exh_found_clr", found, 0);
    wait_done(cyc);
    chk("exh_done_cycle", cyc, 16);
    chk("exh_found", found, 0);
    step(1);
    chk("exh_busy_after", busy, 0);

    // Wrap through FFFFFFFF -> 0
    nonce_start = 32'hfffffffe;
    nonce_end   = 32'h00000001;
    start_run();
    chk("wrap_w3_0", core_if.core_block[415:384], 32'hfeffffff);
    step(5);
    chk("wrap_en_1", core_if.core_en, 1);
    chk("wrap_w3_1", core_if.core_block[415:384], 32'hffffffff);
    step(5);
    chk("wrap_w3_2", core_if.core_block[415:384], 32'h00000000);
    step(5);
    chk("wrap_w3_3", core_if.core_block[415:384], 32'h01000000);
    step(4);
    chk("wrap_done_early", done, 0);
    step(1);
    chk("wrap_done_21", done, 1);
    step(1);

    // Abort during a long search
    nonce_start = 32'd0;
    nonce_end   = 32'h0000ffff;
    start_run();
    step(6);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_en", core_if.core_en, 0);
    seen_done = 1'b0;
    seen_en   = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      seen_done |= done;
      seen_en   |= core_if.core_en;
    end
    chk("abort_no_done", seen_done, 0);
    chk("abort_no_en", seen_en, 0);
    chk("abort_found", found, 0);

    // Start and stop together in idle
    start = 1'b1;
    stop  = 1'b1;
    step(1);
    start = 1'b0;
    stop  = 1'b0;
    chk("ss_busy", busy, 0);
    chk("ss_en", core_if.core_en, 0);
    step(2);
    chk("ss_busy_later", busy, 0);
`ifdef SHA256D_HASH_COUNT_EN
    chk("count_total", hash_count, 11);
`endif

    // Async reset while waiting on the pass-2 result
    nonce_start = 32'd100;
    nonce_end   = 32'd200;
    start_run();
    step(3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_en", core_if.core_en, 0);
    chk("arst_block", core_if.core_block[255:0] | core_if.core_block[511:256], 0);
    chk("arst_mid", core_if.core_midstate, 0);
    chk("arst_found", {found, found_nonce}, 0);
    chk("arst_hash", found_hash, 0);
    step(2);
    rst_n = 1'b1;
    step(3);
    chk("arst_idle", busy, 0);

    cfg_target  = '1;
    nonce_start = 32'h12345678;
    nonce_end   = 32'h12345700;
    start_run();
    wait_done(cyc);
    chk("any_done_cycle", cyc, 6);
    chk("any_found", found, 1);
    chk("any_nonce", found_nonce, 32'h12345678);
    chk("any_hash", found_hash, dsha(gen_mid, gen_tail, 32'h12345678));
`ifdef SHA256D_HASH_COUNT_EN
    chk("count_after_rst", hash_count, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
